// File: rtl/eit_scan_sequencer_if.sv
// Mux-controller and ADC-capture handshake seen by the EIT scan sequencer.
// master = sequencer side, slave = mux controller / ADC side.
interface eit_scan_sequencer_if;
  logic       start_mux;
  logic [7:0] mux_val;
  logic       mux_done;
  logic       adc_start;
  logic       adc_done;

  modport master (
    output start_mux,
    output mux_val,
    output adc_start,
    input  mux_done,
    input  adc_done
  );

  modport slave (
    input  start_mux,
    input  mux_val,
    input  adc_start,
    output mux_done,
    output adc_done
  );
endinterface

// File: rtl/eit_scan_sequencer.sv
// Adjacent-drive EIT frame sequencer: programs the mux for each injection/measurement
// pair, waits for settling, triggers the ADC and steps through N*(N-3) measurements.
module eit_scan_sequencer #(
  parameter int unsigned N_ELEC        = 16,
  parameter int unsigned SETTLE_CYCLES = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_scan,
  input  logic                        continuous,
  input  logic                        abort,
  eit_scan_sequencer_if.master        bus,
  output logic [7:0]                  sample_idx,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SMP_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ELEC - 1);
  localparam logic [IDX_W-1:0] FIRST_MEAS = IDX_W'(2);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX_REQ,
    S_MUX_REL,
    S_SETTLE,
    S_ADC_TRIG,
    S_ADC_WAIT,
    S_ADVANCE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   inj, inj_nxt;
  logic [IDX_W-1:0]   meas, meas_nxt;
  logic [SMP_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               start_mux_q, start_mux_nxt;
  logic               adc_start_q, adc_start_nxt;
  logic               busy_nxt;
  logic               frame_done_nxt;
  logic [IDX_W:0]     next_in_row;
  logic [IDX_W:0]     first_next_row;

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] dec_mod(input logic [IDX_W-1:0] x);
    return (x == '0) ? LAST_IDX : x - IDX_W'(1);
  endfunction

  // A measurement pair may not share an electrode with the injection pair.
  function automatic logic meas_ok(input logic [IDX_W-1:0] inj_i,
                                   input logic [IDX_W-1:0] j_i);
    return (j_i != inj_i) && (j_i != inc_mod(inj_i)) && (j_i != dec_mod(inj_i));
  endfunction

  // Smallest valid j >= from_i for this injection; bit IDX_W flags that one exists.
  function automatic logic [IDX_W:0] find_meas(input logic [IDX_W-1:0] inj_i,
                                               input logic [IDX_W:0]   from_i);
    logic [IDX_W:0] res;
    res = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      if (!res[IDX_W] && (j < N_ELEC) && ((IDX_W+1)'(j) >= from_i) &&
          meas_ok(inj_i, IDX_W'(j))) begin
        res = {1'b1, IDX_W'(j)};
      end
    end
    return res;
  endfunction

  assign next_in_row    = find_meas(inj, {1'b0, meas} + (IDX_W+1)'(1));
  assign first_next_row = find_meas(inc_mod(inj), '0);

  // Next-state, datapath and registered-output selection.
  always_comb begin
    state_nxt      = state;
    inj_nxt        = inj;
    meas_nxt       = meas;
    idx_nxt        = sample_idx;
    cnt_nxt        = cnt;
    frame_done_nxt = 1'b0;

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_scan && !bus.mux_done) begin
            state_nxt = S_MUX_REQ;
            inj_nxt   = '0;
            meas_nxt  = FIRST_MEAS;
            idx_nxt   = '0;
          end
        end
        S_MUX_REQ: begin
          if (bus.mux_done) state_nxt = S_MUX_REL;
        end
        S_MUX_REL: begin
          if (!bus.mux_done) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = SETTLE_LD;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state_nxt = S_ADC_TRIG;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        S_ADC_TRIG: begin
          state_nxt = S_ADC_WAIT;
        end
        S_ADC_WAIT: begin
          if (bus.adc_done) state_nxt = S_ADVANCE;
        end
        S_ADVANCE: begin
          idx_nxt = sample_idx + SMP_W'(1);
          if (next_in_row[IDX_W]) begin
            meas_nxt  = next_in_row[IDX_W-1:0];
            state_nxt = S_MUX_REQ;
          end else if (inj != LAST_IDX) begin
            inj_nxt   = inc_mod(inj);
            meas_nxt  = first_next_row[IDX_W-1:0];
            state_nxt = S_MUX_REQ;
          end else begin
            frame_done_nxt = 1'b1;
            if (continuous) begin
              inj_nxt   = '0;
              meas_nxt  = FIRST_MEAS;
              idx_nxt   = '0;
              state_nxt = S_MUX_REQ;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    start_mux_nxt = (state_nxt == S_MUX_REQ);
    adc_start_nxt = (state_nxt == S_ADC_TRIG);
    busy_nxt      = (state_nxt != S_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      inj         <= '0;
      meas        <= '0;
      sample_idx  <= '0;
      cnt         <= '0;
      start_mux_q <= 1'b0;
      adc_start_q <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      inj         <= inj_nxt;
      meas        <= meas_nxt;
      sample_idx  <= idx_nxt;
      cnt         <= cnt_nxt;
      start_mux_q <= start_mux_nxt;
      adc_start_q <= adc_start_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

  assign bus.start_mux = start_mux_q;
  assign bus.adc_start = adc_start_q;
  assign bus.mux_val   = {inj, meas};

endmodule

// File: tb/tb_eit_scan_sequencer.sv
// Directed bench for eit_scan_sequencer: cycle table on a 16-electrode instance,
// plus frame, continuous, abort and reset sequences with mux/ADC models.
module tb_eit_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 16-electrode instance, settle 4
  logic       ss16, cont16, ab16;
  logic [7:0] si16;
  logic       bz16, fd16;
  logic       mdl_en16, man_md16, man_ad16;
  logic       m_md16 = 1'b0, m_ad16 = 1'b0;
  int         mcnt16 = 0, acnt16 = 0;
  eit_scan_sequencer_if bus16();
  assign bus16.mux_done = mdl_en16 ? m_md16 : man_md16;
  assign bus16.adc_done = mdl_en16 ? m_ad16 : man_ad16;

  eit_scan_sequencer #(.N_ELEC(16), .SETTLE_CYCLES(4)) dut16 (
    .clk(clk), .rst(rst), .start_scan(ss16), .continuous(cont16), .abort(ab16),
    .bus(bus16), .sample_idx(si16), .busy(bz16), .frame_done(fd16));

  // 4-electrode instance, settle 2, always modelled
  logic       ss4, cont4, ab4;
  logic [7:0] si4;
  logic       bz4, fd4;
  logic       m_md4 = 1'b0, m_ad4 = 1'b0;
  int         mcnt4 = 0, acnt4 = 0;
  eit_scan_sequencer_if bus4();
  assign bus4.mux_done = m_md4;
  assign bus4.adc_done = m_ad4;

  eit_scan_sequencer #(.N_ELEC(4), .SETTLE_CYCLES(2)) dut4 (
    .clk(clk), .rst(rst), .start_scan(ss4), .continuous(cont4), .abort(ab4),
    .bus(bus4), .sample_idx(si4), .busy(bz4), .frame_done(fd4));

  // Mux model: done 10 cycles after request, drops once the request drops.
  // ADC model: one-cycle done 3 cycles after the trigger.
  always @(negedge clk) begin
    if (bus16.start_mux && !m_md16) begin
      if (mcnt16 == 9) begin m_md16 = 1'b1; mcnt16 = 0; end
      else mcnt16++;
    end else if (!bus16.start_mux) begin
      m_md16 = 1'b0; mcnt16 = 0;
    end
    m_ad16 = 1'b0;
    if (acnt16 > 0) begin acnt16--; if (acnt16 == 0) m_ad16 = 1'b1; end
    if (bus16.adc_start) acnt16 = 3;
  end

  always @(negedge clk) begin
    if (bus4.start_mux && !m_md4) begin
      if (mcnt4 == 9) begin m_md4 = 1'b1; mcnt4 = 0; end
      else mcnt4++;
    end else if (!bus4.start_mux) begin
      m_md4 = 1'b0; mcnt4 = 0;
    end
    m_ad4 = 1'b0;
    if (acnt4 > 0) begin acnt4--; if (acnt4 == 0) m_ad4 = 1'b1; end
    if (bus4.adc_start) acnt4 = 3;
  end

  // Trigger log: {mux_val, sample_idx} at every adc_start; frame_done counts.
  logic [15:0] q16[$];
  logic [15:0] q4[$];
  int fd_cnt16 = 0, fd_cnt4 = 0;
  always @(negedge clk) begin
    if (bus16.adc_start) q16.push_back({bus16.mux_val, si16});
    if (bus4.adc_start)  q4.push_back({bus4.mux_val, si4});
    if (fd16) fd_cnt16++;
    if (fd4)  fd_cnt4++;
  end

  typedef struct packed {
    logic       ss, ab, md, ad;
    logic       sm;
    logic [7:0] mv;
    logic       st;
    logic       bz;
    logic [7:0] si;
    logic       fd;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic ss, input logic ab, input logic md, input logic ad,
                              input logic sm, input logic [7:0] mv, input logic st,
                              input logic bz, input logic [7:0] si, input logic fd);
    vec_t v;
    v.ss = ss; v.ab = ab; v.md = md; v.ad = ad;
    v.sm = sm; v.mv = mv; v.st = st; v.bz = bz; v.si = si; v.fd = fd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs16();
    return {13'd0, bus16.start_mux, bus16.mux_val, bus16.adc_start, bz16, si16, fd16};
  endfunction

  function automatic logic [31:0] outs4();
    return {13'd0, bus4.start_mux, bus4.mux_val, bus4.adc_start, bz4, si4, fd4};
  endfunction

  // Compares one logged frame against the adjacent-drive ordering.
  task automatic check_frame(input string tag, input int n, input int which, input int base);
    int k;
    logic [15:0] act;
    k = 0;
    for (int inj = 0; inj < n; inj++) begin
      for (int j = 0; j < n; j++) begin
        if (j != inj && j != (inj + 1) % n && j != (inj + n - 1) % n) begin
          if (which == 16) act = (base + k < q16.size()) ? q16[base + k] : 16'hxxxx;
          else             act = (base + k < q4.size())  ? q4[base + k]  : 16'hxxxx;
          check($sformatf("%s[%0d]", tag, k), {16'd0, act},
                {16'd0, 4'(inj), 4'(j), 8'(k)});
          k++;
        end
      end
    end
  endtask

  int  base, fd0, adc0;
  logic got;

  initial begin
    // Cycle table: inputs before an edge, outputs expected just after it.
    //             ss ab md ad   sm mv     st bz si     fd
    vecs[0]  = mk(1, 0, 1, 0,   0, 8'h00, 0, 0, 8'h00, 0); // start while mux_done high
    vecs[1]  = mk(0, 0, 0, 1,   0, 8'h00, 0, 0, 8'h00, 0); // stray adc_done in IDLE
    vecs[2]  = mk(1, 0, 0, 0,   1, 8'h02, 0, 1, 8'h00, 0); // start
    vecs[3]  = mk(0, 0, 0, 0,   1, 8'h02, 0, 1, 8'h00, 0);
    vecs[4]  = mk(0, 0, 1, 0,   0, 8'h02, 0, 1, 8'h00, 0); // mux_done -> release
    vecs[5]  = mk(0, 0, 1, 0,   0, 8'h02, 0, 1, 8'h00, 0);
    vecs[6]  = mk(0, 0, 0, 0,   0, 8'h02, 0, 1, 8'h00, 0); // settle 1
    vecs[7]  = mk(0, 0, 0, 1,   0, 8'h02, 0, 1, 8'h00, 0); // settle 2, stray adc_done
    vecs[8]  = mk(1, 0, 0, 0,   0, 8'h02, 0, 1, 8'h00, 0); // settle 3, start while busy
    vecs[9]  = mk(0, 0, 0, 0,   0, 8'h02, 0, 1, 8'h00, 0); // settle 4
    vecs[10] = mk(0, 0, 0, 0,   0, 8'h02, 1, 1, 8'h00, 0); // trigger
    vecs[11] = mk(0, 0, 0, 0,   0, 8'h02, 0, 1, 8'h00, 0);
    vecs[12] = mk(0, 0, 0, 0,   0, 8'h02, 0, 1, 8'h00, 0);
    vecs[13] = mk(0, 0, 0, 1,   0, 8'h02, 0, 1, 8'h00, 0); // adc_done -> advance
    vecs[14] = mk(0, 0, 0, 0,   1, 8'h03, 0, 1, 8'h01, 0); // next request
    vecs[15] = mk(0, 0, 0, 0,   1, 8'h03, 0, 1, 8'h01, 0);
    vecs[16] = mk(0, 1, 1, 0,   0, 8'h03, 0, 0, 8'h01, 0); // abort
    vecs[17] = mk(0, 0, 0, 1,   0, 8'h03, 0, 0, 8'h01, 0); // late adc_done

    rst = 1'b1;
    ss16 = 0; cont16 = 0; ab16 = 0; mdl_en16 = 0; man_md16 = 0; man_ad16 = 0;
    ss4 = 0; cont4 = 0; ab4 = 0;
    tick(); tick();
    check("reset_outs16", outs16(), 32'd0);
    check("reset_outs4", outs4(), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      ss16 = vecs[i].ss; ab16 = vecs[i].ab; man_md16 = vecs[i].md; man_ad16 = vecs[i].ad;
      tick();
      check($sformatf("table[%0d]", i), outs16(),
            {13'd0, vecs[i].sm, vecs[i].mv, vecs[i].st, vecs[i].bz, vecs[i].si, vecs[i].fd});
    end
    ss16 = 0; ab16 = 0; man_md16 = 0; man_ad16 = 0;
    tick();

    // Abort in the middle of SETTLE: nothing further fires.
    ss16 = 1; tick(); ss16 = 0;
    man_md16 = 1; tick();
    man_md16 = 0; tick();
    tick();
    adc0 = q16.size(); fd0 = fd_cnt16;
    ab16 = 1; tick(); ab16 = 0;
    check("abort_settle_outs", outs16(), {13'd0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0});
    repeat (10) tick();
    check("abort_no_adc", 32'(q16.size() - adc0), 32'd0);
    check("abort_no_fd", 32'(fd_cnt16 - fd0), 32'd0);

    // Full 16-electrode frame through the models.
    mdl_en16 = 1;
    tick(); tick();
    base = q16.size(); fd0 = fd_cnt16;
    ss16 = 1; tick(); ss16 = 0;
    check("start_latency16", outs16(), {13'd0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0});
    for (int c = 0; c < 20000 && fd_cnt16 == fd0; c++) tick();
    repeat (3) tick();
    check("frame16_fd_count", 32'(fd_cnt16 - fd0), 32'd1);
    check("frame16_len", 32'(q16.size() - base), 32'd208);
    check("frame16_busy_low", {31'd0, bz16}, 32'd0);
    check_frame("frame16", 16, 16, base);

    // Four-electrode frame.
    tick();
    base = q4.size(); fd0 = fd_cnt4;
    ss4 = 1; tick(); ss4 = 0;
    check("start_latency4", outs4(), {13'd0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0});
    for (int c = 0; c < 2000 && fd_cnt4 == fd0; c++) tick();
    repeat (3) tick();
    check("frame4_fd_count", 32'(fd_cnt4 - fd0), 32'd1);
    check("frame4_len", 32'(q4.size() - base), 32'd4);
    check("frame4_busy_low", {31'd0, bz4}, 32'd0);
    check_frame("frame4", 4, 4, base);

    // Continuous: back-to-back frames with no IDLE cycle in between.
    tick();
    base = q4.size();
    cont4 = 1;
    ss4 = 1; tick(); ss4 = 0;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (fd4) begin got = 1'b1; break; end
    end
    check("cont_fd1_seen", {31'd0, got}, 32'd1);
    check("cont_restart", {22'd0, bz4, bus4.start_mux, bus4.mux_val, si4},
          {22'd0, 1'b1, 1'b1, 8'h02, 8'h00});
    cont4 = 0;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (fd4) begin got = 1'b1; break; end
    end
    check("cont_fd2_seen", {31'd0, got}, 32'd1);
    repeat (3) tick();
    check("cont_busy_low", {31'd0, bz4}, 32'd0);
    check("cont_len", 32'(q4.size() - base), 32'd8);
    check_frame("cont_f1", 4, 4, base);
    check_frame("cont_f2", 4, 4, base + 4);

    // Asynchronous reset in the middle of a 16-electrode frame.
    tick();
    ss16 = 1; tick(); ss16 = 0;
    repeat (300) tick();
    check("pre_reset_busy", {31'd0, bz16}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_outs16", outs16(), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    base = q16.size();
    ss16 = 1; tick(); ss16 = 0;
    check("restart_after_reset", outs16(), {13'd0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0});
    for (int c = 0; c < 200 && q16.size() == base; c++) tick();
    check("restart_first_trigger",
          {16'd0, (q16.size() > base) ? q16[base] : 16'hxxxx}, {16'd0, 8'h02, 8'h00});
    ab16 = 1; tick(); ab16 = 0;
    check("final_abort_idle", {31'd0, bz16}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
